layer_demapping: RTL and testbench



---
 rtl/layer_map_pkg.sv | 13 +
 rtl/layer_demap_bank.sv | 78 +++++++
 rtl/layer_demapping.sv | 127 ++++++++++++
 tb/tb_layer_demapping.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/layer_map_pkg.sv
// Shared constants and symbol indexing for the 8-layer, two-codeword
// layer mapper and its receive-side inverse.
package layer_map_pkg;

   localparam int SYM_W         = 32;
   localparam int NLAYERS       = 8;
   localparam int LAYERS_PER_CW = 4;

   function automatic int cw_sym_index(input int beat, input int layer);
      return LAYERS_PER_CW * beat + layer;
   endfunction

endpackage

// File: rtl/layer_demap_bank.sv
// One ping-pong bank: two codeword registers filled one beat at a time,
// plus the flag saying the pair is complete and waiting for the consumer.
module layer_demap_bank #(
   parameter int SYM_W         = 32,
   parameter int SYM_PER_LAYER = 2,
   parameter int CNT_W         = 1,
   localparam int CW_W         = 4 * SYM_PER_LAYER * SYM_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               wr_en,
   input  logic [CNT_W-1:0]   wr_beat,
   input  logic [8*SYM_W-1:0] wr_syms,
   input  logic               set_full,
   input  logic               clr_full,
   output logic               full,
   output logic [0:CW_W-1]    cw0,
   output logic [0:CW_W-1]    cw1
);
   import layer_map_pkg::*;

   localparam int NSYM = LAYERS_PER_CW * SYM_PER_LAYER;

   logic [SYM_W-1:0] cw0_q [NSYM];
   logic [SYM_W-1:0] cw0_d [NSYM];
   logic [SYM_W-1:0] cw1_q [NSYM];
   logic [SYM_W-1:0] cw1_d [NSYM];
   logic             full_q;
   logic             full_d;

   always_comb begin
      cw0_d  = cw0_q;
      cw1_d  = cw1_q;
      full_d = full_q;
      if (wr_en) begin
         for (int b = 0; b < SYM_PER_LAYER; b++) begin
            for (int k = 0; k < LAYERS_PER_CW; k++) begin
               if (wr_beat == CNT_W'(b)) begin
                  // layer1 sits at the MSB end of the beat
                  cw0_d[cw_sym_index(b, k)] =
                     wr_syms[(NLAYERS - k) * SYM_W - 1 -: SYM_W];
                  cw1_d[cw_sym_index(b, k)] =
                     wr_syms[(NLAYERS - LAYERS_PER_CW - k) * SYM_W - 1 -: SYM_W];
               end
            end
         end
      end
      if (set_full) begin
         full_d = 1'b1;
      end else if (clr_full) begin
         full_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cw0_q  <= '{default: '0};
         cw1_q  <= '{default: '0};
         full_q <= 1'b0;
      end else begin
         cw0_q  <= cw0_d;
         cw1_q  <= cw1_d;
         full_q <= full_d;
      end
   end

   always_comb begin
      cw0 = '0;
      cw1 = '0;
      for (int j = 0; j < NSYM; j++) begin
         cw0[j * SYM_W +: SYM_W] = cw0_q[j];
         cw1[j * SYM_W +: SYM_W] = cw1_q[j];
      end
   end

   assign full = full_q;

endmodule

// File: rtl/layer_demapping.sv
// Receive-side layer demapper: rebuilds two codewords from 8-layer beats
// into ping-pong banks, with framing checks on in_first.
module layer_demapping #(
   parameter int SYM_W         = layer_map_pkg::SYM_W,
   parameter int SYM_PER_LAYER = 2,
   localparam int CW_W         = 4 * SYM_PER_LAYER * SYM_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic               in_first,
   input  logic [8*SYM_W-1:0] layer_sym,
   output logic               cw_valid,
   input  logic               cw_ready,
   output logic [0:CW_W-1]    codeword0,
   output logic [0:CW_W-1]    codeword1,
   output logic               sync_err
);
   import layer_map_pkg::*;

   localparam int CNT_W = (SYM_PER_LAYER > 1) ? $clog2(SYM_PER_LAYER) : 1;

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             wr_q, wr_d;
   logic             rd_q, rd_d;
   logic             err_q, err_d;

   logic             acc;
   logic             pop;
   logic             we;
   logic             done;
   logic [CNT_W-1:0] wbeat;
   logic [1:0]       full;
   logic [1:0]       bank_we;
   logic [1:0]       bank_set;
   logic [1:0]       bank_clr;
   logic [0:CW_W-1]  bank_cw0 [2];
   logic [0:CW_W-1]  bank_cw1 [2];

   assign in_ready  = !rst && !full[wr_q];
   assign cw_valid  = full[rd_q];
   assign codeword0 = bank_cw0[rd_q];
   assign codeword1 = bank_cw1[rd_q];
   assign sync_err  = err_q;
   assign acc       = in_valid && in_ready;
   assign pop       = cw_valid && cw_ready;

   always_comb begin
      cnt_d = cnt_q;
      wr_d  = wr_q;
      rd_d  = rd_q;
      err_d = err_q;
      we    = 1'b0;
      done  = 1'b0;
      wbeat = '0;
      if (acc) begin
         if (in_first) begin
            // restart framing; any partial pair is simply overwritten
            we = 1'b1;
            if (cnt_q != '0) err_d = 1'b1;
            if (SYM_PER_LAYER == 1) begin
               done  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = CNT_W'(1);
            end
         end else if (cnt_q == '0) begin
            err_d = 1'b1;
         end else begin
            we    = 1'b1;
            wbeat = cnt_q;
            if (cnt_q == CNT_W'(SYM_PER_LAYER - 1)) begin
               done  = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      end
      if (done) wr_d = ~wr_q;
      if (pop)  rd_d = ~rd_q;
   end

   always_comb begin
      bank_we        = '0;
      bank_set       = '0;
      bank_clr       = '0;
      bank_we[wr_q]  = we;
      bank_set[wr_q] = done;
      bank_clr[rd_q] = pop;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
         wr_q  <= 1'b0;
         rd_q  <= 1'b0;
         err_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         wr_q  <= wr_d;
         rd_q  <= rd_d;
         err_q <= err_d;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_bank
      layer_demap_bank #(
         .SYM_W         (SYM_W),
         .SYM_PER_LAYER (SYM_PER_LAYER),
         .CNT_W         (CNT_W)
      ) u_bank (
         .clk      (clk),
         .rst      (rst),
         .wr_en    (bank_we[g]),
         .wr_beat  (wbeat),
         .wr_syms  (layer_sym),
         .set_full (bank_set[g]),
         .clr_full (bank_clr[g]),
         .full     (full[g]),
         .cw0      (bank_cw0[g]),
         .cw1      (bank_cw1[g])
      );
   end

endmodule

// File: tb/tb_layer_demapping.sv
// Directed and randomized bench for layer_demapping at default parameters.
module tb_layer_demapping;

   logic         clk = 1'b0;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic         in_first;
   logic [255:0] layer_sym;
   logic         cw_valid;
   logic         cw_ready;
   logic [0:255] codeword0;
   logic [0:255] codeword1;
   logic         sync_err;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   logic [255:0] rx0 [$];
   logic [255:0] rx1 [$];
   int           rxt [$];
   logic [255:0] ex0 [$];
   logic [255:0] ex1 [$];

   layer_demapping dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_first  (in_first),
      .layer_sym (layer_sym),
      .cw_valid  (cw_valid),
      .cw_ready  (cw_ready),
      .codeword0 (codeword0),
      .codeword1 (codeword1),
      .sync_err  (sync_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // handshake inputs change at posedge+1, so negedge sees the settled values
   always @(negedge clk) begin
      if (!rst && cw_valid && cw_ready) begin
         rx0.push_back(codeword0);
         rx1.push_back(codeword1);
         rxt.push_back(cyc);
      end
   end

   task automatic check(input string tag, input logic [255:0] got,
                        input logic [255:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [255:0] rnd256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
      return r;
   endfunction

   task automatic send_beat(input logic f, input logic [255:0] d);
      int   n;
      logic ok;
      n = 0;
      ok = 1'b0;
      in_valid = 1'b1;
      in_first = f;
      layer_sym = d;
      while (!ok && n < 2000) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!ok) check("beat_timeout", 256'(ok), 256'(1));
      in_valid = 1'b0;
      in_first = 1'b0;
   endtask

   // codeword0 = layers1-4 of beat0 then beat1; codeword1 = layers5-8
   task automatic send_pair(input logic [255:0] p0, input logic [255:0] p1);
      ex0.push_back({p0[255:128], p1[255:128]});
      ex1.push_back({p0[127:0], p1[127:0]});
      send_beat(1'b1, p0);
      send_beat(1'b0, p1);
   endtask

   task automatic wait_rx(input string tag, input int n);
      int t;
      t = 0;
      while (rx0.size() < n && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check(tag, 256'(rx0.size()), 256'(n));
   endtask

   task automatic compare_all(input string tag);
      wait_rx({tag, "_count"}, ex0.size());
      while (ex0.size() > 0 && rx0.size() > 0) begin
         check({tag, "_cw0"}, rx0.pop_front(), ex0.pop_front());
         check({tag, "_cw1"}, rx1.pop_front(), ex1.pop_front());
         void'(rxt.pop_front());
      end
      repeat (4) @(negedge clk);
      check({tag, "_extra"}, 256'(rx0.size()), 256'(0));
      rx0.delete();
      rx1.delete();
      rxt.delete();
      ex0.delete();
      ex1.delete();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      layer_sym = '0;
      repeat (2) @(posedge clk);
      #1;
      rx0.delete();
      rx1.delete();
      rxt.delete();
      ex0.delete();
      ex1.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
   endtask

   logic [255:0] c0b0, c0b1, e0, e1, aaaa, hold0, hold1;
   logic [255:0] a0, a1, b0, b1, d0, d1;
   bit           done6;

   initial begin
      cw_ready = 1'b1;
      c0b0 = {32'h0, 32'h1, 32'h2, 32'h3,
              32'h1_0000, 32'h1_0001, 32'h1_0002, 32'h1_0003};
      c0b1 = {32'h4, 32'h5, 32'h6, 32'h7,
              32'h1_0004, 32'h1_0005, 32'h1_0006, 32'h1_0007};
      for (int j = 0; j < 8; j++) begin
         e0[255 - 32*j -: 32] = 32'(j);
         e1[255 - 32*j -: 32] = 32'h1_0000 | 32'(j);
      end
      aaaa = {32'hAAAA_0000, 32'hAAAA_0001, 32'hAAAA_0002, 32'hAAAA_0003,
              32'hBBBB_0000, 32'hBBBB_0001, 32'hBBBB_0002, 32'hBBBB_0003};

      rst = 1'b1;
      in_valid = 1'b0;
      in_first = 1'b0;
      layer_sym = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_in_ready", 256'(in_ready), 256'(0));
      check("rst_cw_valid", 256'(cw_valid), 256'(0));
      check("rst_cw0", codeword0, '0);
      check("rst_cw1", codeword1, '0);
      check("rst_sync_err", 256'(sync_err), 256'(0));
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("post_rst_in_ready", 256'(in_ready), 256'(1));

      // 1: single pair, fixed latency
      send_beat(1'b1, c0b0);
      check("s1_valid_mid", 256'(cw_valid), 256'(0));
      send_beat(1'b0, c0b1);
      check("s1_valid_lat", 256'(cw_valid), 256'(1));
      ex0.push_back(e0);
      ex1.push_back(e1);
      compare_all("s1");
      check("s1_sync_err", 256'(sync_err), 256'(0));

      // 2: backpressure with two buffered pairs and a held third
      cw_ready = 1'b0;
      a0 = rnd256(); a1 = rnd256();
      b0 = rnd256(); b1 = rnd256();
      d0 = rnd256(); d1 = rnd256();
      send_pair(a0, a1);
      send_pair(b0, b1);
      @(negedge clk);
      check("s2_full_ready", 256'(in_ready), 256'(0));
      check("s2_full_valid", 256'(cw_valid), 256'(1));
      hold0 = codeword0;
      hold1 = codeword1;
      check("s2_hold_is_a", hold0, {a0[255:128], a1[255:128]});
      fork
         send_pair(d0, d1);
         begin
            repeat (3) @(negedge clk);
            check("s2_stall_cw0", codeword0, hold0);
            check("s2_stall_cw1", codeword1, hold1);
            check("s2_stall_ready", 256'(in_ready), 256'(0));
            @(posedge clk);
            #1;
            cw_ready = 1'b1;
         end
      join
      wait_rx("s2_two_out", 2);
      check("s2_b2b", 256'(rxt[1] - rxt[0]), 256'(1));
      compare_all("s2");

      // 3: early in_first discards the partial pair
      do_reset();
      send_beat(1'b1, aaaa);
      send_beat(1'b1, c0b0);
      send_beat(1'b0, c0b1);
      ex0.push_back(e0);
      ex1.push_back(e1);
      compare_all("s3");
      check("s3_sync_err", 256'(sync_err), 256'(1));

      // 4: missing in_first drops the stray beat
      do_reset();
      send_beat(1'b0, aaaa);
      check("s4_sync_err", 256'(sync_err), 256'(1));
      check("s4_no_valid", 256'(cw_valid), 256'(0));
      send_pair(c0b0, c0b1);
      compare_all("s4");
      check("s4_sync_sticky", 256'(sync_err), 256'(1));

      // 5: async reset with one pair buffered and another half built
      do_reset();
      cw_ready = 1'b0;
      send_pair(aaaa, c0b0);
      send_beat(1'b1, aaaa);
      #3;
      rst = 1'b1;
      #1;
      check("s5_rst_valid", 256'(cw_valid), 256'(0));
      check("s5_rst_cw0", codeword0, '0);
      check("s5_rst_cw1", codeword1, '0);
      check("s5_rst_ready", 256'(in_ready), 256'(0));
      ex0.delete();
      ex1.delete();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      #1;
      cw_ready = 1'b1;
      send_pair(c0b0, c0b1);
      compare_all("s5");
      check("s5_sync_err", 256'(sync_err), 256'(0));

      // 6: random pairs with random input gaps and consumer stalls
      done6 = 1'b0;
      fork
         begin
            for (int p = 0; p < 100; p++) begin
               repeat ($urandom_range(0, 2)) begin
                  @(posedge clk);
                  #1;
               end
               send_pair(rnd256(), rnd256());
            end
            done6 = 1'b1;
         end
         begin
            while (!done6) begin
               @(posedge clk);
               #1;
               cw_ready = 1'($urandom_range(0, 1));
            end
            cw_ready = 1'b1;
         end
      join
      compare_all("s6");
      check("s6_sync_err", 256'(sync_err), 256'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
